// File: rtl/sdm_decim.sv
// sdm_decim: third-order CIC decimator for a 1-bit sigma-delta bitstream.
// Three registered integrators run at the fast rate. Every 2^LOG2R cycles a
// three-stage comb produces one sample, which is scaled down to DW unsigned
// bits. A full-scale input (all ones) is saturated to the largest code.
// A short warm-up hides the first samples while the comb delays fill.
module sdm_decim #(
    parameter int DW    = 12,
    parameter int LOG2R = 6
) (
    input  logic          clk_fast,
    input  logic          rst,
    input  logic          din,
    output logic [DW-1:0] dout,
    output logic          dout_valid
);

    // Internal width: enough for R^3 plus one bit, so full scale shows up as the top bit.
    localparam int W     = 3 * LOG2R + 1;
    localparam int SHIFT = 3 * LOG2R - DW;

    generate
        if (3 * LOG2R < DW) begin : g_bad_params
            $error("sdm_decim: 3*LOG2R must be >= DW");
        end
    endgenerate

    logic [W-1:0]     i1, i2, i3;
    logic [W-1:0]     d1, d2, d3;
    logic [W-1:0]     c1, c2, c3;
    logic [W-1:0]     c3_shifted;
    logic [LOG2R-1:0] cnt;
    logic [1:0]       warm;
    logic             dec_edge;
    logic             sat;
    logic [DW-1:0]    pcm_next;

    // Comb chain, decimation-edge detect and output scaling/saturation.
    always_comb begin
        dec_edge   = (cnt == '1);
        c1         = i3 - d1;
        c2         = c1 - d2;
        c3         = c2 - d3;
        c3_shifted = c3 >> SHIFT;
        sat        = |c3_shifted[W-1:DW];
        pcm_next   = sat ? '1 : c3_shifted[DW-1:0];
    end

    // Integrator cascade: each stage adds the previous stage's registered value, so it wraps freely.
    always_ff @(posedge clk_fast) begin
        if (rst) begin
            i1 <= '0;
            i2 <= '0;
            i3 <= '0;
        end else begin
            i1 <= i1 + W'(din);
            i2 <= i2 + i1;
            i3 <= i3 + i2;
        end
    end

    // Decimation counter: free-running, all-ones marks the decimation edge.
    always_ff @(posedge clk_fast) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Comb delay registers: capture the comb inputs only on decimation edges.
    always_ff @(posedge clk_fast) begin
        if (rst) begin
            d1 <= '0;
            d2 <= '0;
            d3 <= '0;
        end else if (dec_edge) begin
            d1 <= i3;
            d2 <= c1;
            d3 <= c2;
        end
    end

    // Output register, valid strobe and warm-up count; the first three samples load dout but stay invisible.
    always_ff @(posedge clk_fast) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            warm       <= 2'd0;
        end else if (dec_edge) begin
            dout       <= pcm_next;
            dout_valid <= (warm == 2'd3);
            if (warm != 2'd3) begin
                warm <= warm + 2'd1;
            end
        end else begin
            dout_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sdm_decim.sv
// tb_sdm_decim: randomized and directed stimulus for sdm_decim, checked
// against a reference that convolves the bitstream history with the CIC
// impulse response (three cascaded length-R boxcars) every R cycles.
module tb_sdm_decim;

    localparam int DW    = 12;
    localparam int LOG2R = 6;
    localparam int R     = 1 << LOG2R;
    localparam int R3    = R * R * R;
    localparam int NTAP  = 3 * R - 2;
    localparam int MAXE  = 4096;

    logic          clk_fast = 1'b0;
    logic          rst      = 1'b1;
    logic          din      = 1'b0;
    logic [DW-1:0] dout;
    logic          dout_valid;

    int total = 0;
    int bad   = 0;

    int  h [NTAP];
    bit  xh[MAXE];
    int  nedge = 0;
    logic [DW-1:0] exp_dout  = '0;
    logic          exp_valid = 1'b0;

    sdm_decim #(.DW(DW), .LOG2R(LOG2R)) dut (
        .clk_fast  (clk_fast),
        .rst       (rst),
        .din       (din),
        .dout      (dout),
        .dout_valid(dout_valid)
    );

    // Free-running fast clock.
    always #5 clk_fast = ~clk_fast;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0d want %0d (edge %0d)", tag, got, want, nedge);
        end
    endtask

    // Impulse response of three cascaded length-R moving sums.
    task automatic buildImpulse();
        for (int k = 0; k < NTAP; k++) h[k] = 0;
        for (int a = 0; a < R; a++)
            for (int b = 0; b < R; b++)
                for (int c = 0; c < R; c++)
                    h[a + b + c]++;
    endtask

    // Filter output at edge e: three-sample pipeline delay, inputs before reset count as zero.
    function automatic int cicSum(input int e);
        int s = 0;
        for (int k = 0; k < NTAP; k++) begin
            int j = e - 3 - k;
            if (j >= 1 && xh[j]) s += h[k];
        end
        return s;
    endfunction

    task automatic modelEdge(input bit d, input bit r);
        if (r) begin
            nedge     = 0;
            exp_valid = 1'b0;
            exp_dout  = '0;
        end else begin
            int c3;
            nedge++;
            xh[nedge] = d;
            exp_valid = 1'b0;
            if (nedge % R == 0) begin
                c3        = cicSum(nedge);
                exp_dout  = (c3 >= R3) ? DW'((1 << DW) - 1) : DW'(c3 >> (3 * LOG2R - DW));
                exp_valid = (nedge / R >= 4);
            end
        end
    endtask

    task automatic applyStimulus(input bit d, input bit r);
        @(negedge clk_fast);
        din = d;
        rst = r;
        @(posedge clk_fast);
        modelEdge(d, r);
        #1;
        checkOutput("valid", dout_valid, exp_valid);
        checkOutput("dout", dout, exp_dout);
    endtask

    initial begin
        int sdm_acc;
        int p;
        bit b;
        buildImpulse();

        $display("[TB] reset state");
        repeat (3) applyStimulus(1'b0, 1'b1);

        $display("[TB] all ones");
        for (int n = 0; n < 6 * R; n++) begin
            applyStimulus(1'b1, 1'b0);
            if (exp_valid) checkOutput("ones_sat", dout, 4095);
        end

        $display("[TB] all zeros");
        repeat (2) applyStimulus(1'b1, 1'b1);
        for (int n = 0; n < 5 * R; n++) begin
            applyStimulus(1'b0, 1'b0);
            if (exp_valid) checkOutput("zeros", dout, 0);
        end
        checkOutput("i3_zero", dut.i3, 0);

        $display("[TB] alternating");
        applyStimulus(1'b0, 1'b1);
        for (int n = 0; n < 5 * R; n++) begin
            applyStimulus(n % 2 == 0, 1'b0);
            if (exp_valid) checkOutput("alt_half", dout, 2048);
        end

        $display("[TB] quarter density then ones");
        applyStimulus(1'b0, 1'b1);
        for (int n = 0; n < 5 * R; n++) begin
            applyStimulus(n % 4 == 0, 1'b0);
            if (exp_valid) checkOutput("quarter", dout, 1024);
        end
        for (int n = 0; n < 4 * R; n++) begin
            applyStimulus(1'b1, 1'b0);
            if (exp_valid && n >= 3 * R) checkOutput("switch_sat", dout, 4095);
        end

        $display("[TB] reset on a decimation edge");
        applyStimulus(1'b0, 1'b1);
        for (int n = 0; n < 4 * R + 17; n++) applyStimulus(1'($urandom), 1'b0);
        while (nedge % R != R - 1) applyStimulus(1'($urandom), 1'b0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("rst_no_valid", dout_valid, 0);
        checkOutput("rst_dout", dout, 0);
        for (int n = 1; n <= 6 * R; n++) begin
            applyStimulus(1'($urandom), 1'b0);
            if (n <= 4 * R) checkOutput("rst_first_pulse", dout_valid, n == 4 * R);
        end

        $display("[TB] random densities");
        for (int t = 0; t < 3; t++) begin
            p = $urandom_range(0, 100);
            applyStimulus(1'b0, 1'b1);
            for (int n = 0; n < 5 * R; n++) applyStimulus($urandom_range(0, 99) < p, 1'b0);
        end

        $display("[TB] first-order modulator at code 1000");
        applyStimulus(1'b0, 1'b1);
        sdm_acc = 0;
        for (int n = 0; n < 8 * R; n++) begin
            sdm_acc += 1000;
            if (sdm_acc >= 4096) begin
                b = 1'b1;
                sdm_acc -= 4096;
            end else begin
                b = 1'b0;
            end
            applyStimulus(b, 1'b0);
            if (exp_valid) checkOutput("sdm_range", (int'(dout) >= 992 && int'(dout) <= 1008), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
